// File: rtl/mem_writeback_pkg.sv
// Shared types for the memory write-back path.
// Defaults match the ram and mux4 blocks.
package mem_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } wb_state_e;

  localparam int DEF_ADDRESS_BITS = 5;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/mem_writeback_fifo.sv
// Write queue: power-of-two FIFO with occupancy count.
// Head entry is visible combinationally.
module wb_fifo
  import mem_writeback_pkg::*;
#(
  parameter  int W     = DEF_ADDRESS_BITS + DEF_DATA_BITS,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mem_writeback.sv
// Buffered RAM write-back: queues writes and issues
// them in the execute slot or back-to-back on flush.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter  int ADDRESS_BITS = DEF_ADDRESS_BITS,
  parameter  int DATA_BITS    = DEF_DATA_BITS,
  parameter  int DEPTH        = 4,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    execute,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDRESS_BITS-1:0] req_address,
  input  logic [DATA_BITS-1:0]    req_data,
  output logic                    ram_w_enable,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0]    ram_data_in,
  output logic [CW-1:0]           count,
  output logic                    busy
);

  localparam int W = ADDRESS_BITS + DATA_BITS;

  wb_state_e     state_q;
  wb_state_e     state_d;
  logic          push;
  logic          pop;
  logic [W-1:0]  head;
  logic [CW-1:0] count_next;

  assign req_ready = enable
                   && (count < CW'(DEPTH))
                   && (state_q != DRAIN);
  assign push = req_valid && req_ready;
  assign pop  = enable && (count != '0)
              && (execute || (state_q == DRAIN));
  assign count_next = count + CW'(push) - CW'(pop);
  assign busy = (state_q != IDLE);

  wb_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   ({req_address, req_data}),
    .head    (head),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (flush && (count != '0)) state_d = DRAIN;
          else if (push)              state_d = ACTIVE;
        end
        ACTIVE: begin
          if (count_next == '0) state_d = IDLE;
          else if (flush)       state_d = DRAIN;
        end
        DRAIN: begin
          if (count_next == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_w_enable <= 1'b0;
      ram_address  <= '0;
      ram_data_in  <= '0;
    end else begin
      ram_w_enable <= pop;
      if (pop) {ram_address, ram_data_in} <= head;
    end
  end

endmodule
